audio_in_receiver: RTL and testbench

AUDIO_IN_RECEIVER -- requirements
Module: audio_in_receiver

---
 rtl/audio_in_receiver.sv | 197 +++++++++++++++++++
 tb/tb_audio_in_receiver.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_in_receiver.sv
// I2S audio ADC receiver: synchronizes the codec serial interface into CLOCK_50,
// deserializes left/right words and buffers stereo pairs in a show-ahead FIFO.
module audio_in_receiver #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          CLOCK_50,
    input  logic                          nReset,
    input  logic                          AUD_BCLK,
    input  logic                          AUD_ADCLRCK,
    input  logic                          AUD_ADCDAT,
    input  logic                          clear_audio_in_memory,
    input  logic                          read_audio_in,
    output logic                          audio_in_available,
    output logic [DATA_WIDTH-1:0]         left_channel_audio_in,
    output logic [DATA_WIDTH-1:0]         right_channel_audio_in,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DELAY, SHIFT, HOLD} state_t;

    logic [2:0]            bclk_sh_q, bclk_sh_d;
    logic [2:0]            lrck_sh_q, lrck_sh_d;
    logic [1:0]            dat_sh_q, dat_sh_d;
    state_t                state_q, state_d;
    logic                  chan_q, chan_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] left_word_q, left_word_d;
    logic                  have_left_q, have_left_d;
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] left_mem_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] right_mem_q [FIFO_DEPTH];

    logic                  bclk_rise, lrck_edge, lrck_fall, lrck_lvl, dat_bit;
    logic                  latch, push, push_ok, pop_ok, empty, full;
    logic [DATA_WIDTH-1:0] latch_word;
    logic [CW-1:0]         bit_pos;

    // Stage 0/1 are the two synchronizer flops; stage 2 holds the previous value for edge detection.
    always_comb begin
        bclk_sh_d = {bclk_sh_q[1:0], AUD_BCLK};
        lrck_sh_d = {lrck_sh_q[1:0], AUD_ADCLRCK};
        dat_sh_d  = {dat_sh_q[0], AUD_ADCDAT};
    end

    assign bclk_rise = bclk_sh_q[1] & ~bclk_sh_q[2];
    assign lrck_edge = lrck_sh_q[1] ^ lrck_sh_q[2];
    assign lrck_fall = ~lrck_sh_q[1] & lrck_sh_q[2];
    assign lrck_lvl  = lrck_sh_q[1];
    assign dat_bit   = dat_sh_q[1];
    assign bit_pos   = CW'(DATA_WIDTH - 1) - bit_cnt_q;

    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        left_word_d = left_word_q;
        have_left_d = have_left_q;
        latch       = 1'b0;
        latch_word  = shift_q;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                have_left_d = 1'b0;
                if (lrck_fall) begin
                    state_d = DELAY;
                    chan_d  = 1'b0;
                end
            end
            DELAY: begin
                if (lrck_edge) begin
                    chan_d = lrck_lvl;
                end else if (bclk_rise) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            SHIFT: begin
                // Bits land MSB-first at their final position, so an early stop is already zero-filled.
                if (lrck_edge) begin
                    latch      = 1'b1;
                    latch_word = shift_q;
                    state_d    = DELAY;
                    chan_d     = lrck_lvl;
                end else if (bclk_rise) begin
                    shift_d   = shift_q | ({{(DATA_WIDTH-1){1'b0}}, dat_bit} << bit_pos);
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                        latch      = 1'b1;
                        latch_word = shift_d;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (lrck_edge) begin
                    state_d = DELAY;
                    chan_d  = lrck_lvl;
                end
            end
            default: state_d = IDLE;
        endcase

        if (latch) begin
            if (!chan_q) begin
                left_word_d = latch_word;
                have_left_d = 1'b1;
            end else if (have_left_q) begin
                push        = 1'b1;
                have_left_d = 1'b0;
            end
        end

        if (clear_audio_in_memory) begin
            state_d     = IDLE;
            have_left_d = 1'b0;
            push        = 1'b0;
        end
    end

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = read_audio_in & ~empty & ~clear_audio_in_memory;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (clear_audio_in_memory) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (pop_ok)
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            if (push_ok)
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (push && !push_ok)
                overflow_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            bclk_sh_q   <= '0;
            lrck_sh_q   <= '0;
            dat_sh_q    <= '0;
            state_q     <= IDLE;
            chan_q      <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            left_word_q <= '0;
            have_left_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            bclk_sh_q   <= bclk_sh_d;
            lrck_sh_q   <= lrck_sh_d;
            dat_sh_q    <= dat_sh_d;
            state_q     <= state_d;
            chan_q      <= chan_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            left_word_q <= left_word_d;
            have_left_q <= have_left_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge CLOCK_50) begin
        if (push_ok) begin
            left_mem_q[wr_ptr_q[AW-1:0]]  <= left_word_q;
            right_mem_q[wr_ptr_q[AW-1:0]] <= latch_word;
        end
    end

    assign audio_in_available     = ~empty;
    assign left_channel_audio_in  = empty ? '0 : left_mem_q[rd_ptr_q[AW-1:0]];
    assign right_channel_audio_in = empty ? '0 : right_mem_q[rd_ptr_q[AW-1:0]];
    assign overflow               = overflow_q;
    assign fill_level             = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_audio_in_receiver.sv
// Bench for audio_in_receiver: drives I2S frames (BCLK = CLOCK_50/8) and checks the
// FIFO contents against a queue model of the captured stereo pairs.
module tb_audio_in_receiver;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int HALF  = 36;

    logic          CLOCK_50 = 1'b0;
    logic          nReset = 1'b0;
    logic          AUD_BCLK = 1'b0;
    logic          AUD_ADCLRCK = 1'b0;
    logic          AUD_ADCDAT = 1'b0;
    logic          clear = 1'b0;
    logic          rd = 1'b0;
    logic          avail_o;
    logic [DW-1:0] left_o, right_o;
    logic          ovf_o;
    logic [3:0]    fill_o;

    int            n_cmp = 0;
    int            n_fail = 0;
    logic [2*DW-1:0] exp_q[$];
    logic          model_ovf = 1'b0;
    logic          avail_n6, avail_n7;

    audio_in_receiver #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK_50(CLOCK_50), .nReset(nReset), .AUD_BCLK(AUD_BCLK),
        .AUD_ADCLRCK(AUD_ADCLRCK), .AUD_ADCDAT(AUD_ADCDAT),
        .clear_audio_in_memory(clear), .read_audio_in(rd),
        .audio_in_available(avail_o), .left_channel_audio_in(left_o),
        .right_channel_audio_in(right_o), .overflow(ovf_o), .fill_level(fill_o)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // A word cut short keeps only the bits actually sent, MSB-aligned.
    function automatic logic [DW-1:0] captured(input logic [DW-1:0] val, input int slots);
        logic [DW-1:0] mask;
        if (slots >= DW) return val;
        mask = '1;
        mask = mask << (DW - slots);
        return val & mask;
    endfunction

    task automatic model_push(input logic [DW-1:0] l, input logic [DW-1:0] r);
        if (exp_q.size() < DEPTH) exp_q.push_back({l, r});
        else model_ovf = 1'b1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        model_ovf = 1'b0;
    endtask

    // One BCLK period of 8 CLOCK_50 cycles. mode: 1 = read, 3 = clear, pulsed on the
    // cycle the synchronized rise acts; 2 = sample availability around that cycle.
    task automatic bclk_cycle(input logic b, input logic lr, input int mode);
        @(negedge CLOCK_50);
        AUD_BCLK = 1'b0; AUD_ADCDAT = b; AUD_ADCLRCK = lr;
        repeat (4) @(negedge CLOCK_50);
        AUD_BCLK = 1'b1;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        if (mode == 2) avail_n6 = avail_o;
        if (mode == 1) rd = 1'b1;
        if (mode == 3) clear = 1'b1;
        @(negedge CLOCK_50);
        rd = 1'b0; clear = 1'b0;
        if (mode == 2) avail_n7 = avail_o;
    endtask

    // Cycle 0 carries the skipped slot after the LRCK change; cycles 1..slots carry MSB first.
    task automatic send_half(input logic lr, input logic [DW-1:0] val, input int slots,
                             input int total, input int mode);
        logic b;
        for (int i = 0; i < total; i++) begin
            b = 1'($urandom_range(0, 1));
            if (i >= 1 && i <= slots) b = val[DW-i];
            bclk_cycle(b, lr, (i == slots) ? mode : 0);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int slots,
                              input int total, input int mode);
        send_half(1'b0, l, slots, total, 0);
        send_half(1'b1, r, slots, total, mode);
    endtask

    task automatic preamble();
        for (int i = 0; i < 4; i++) bclk_cycle(1'($urandom_range(0, 1)), 1'b1, 0);
    endtask

    task automatic pulse_clear();
        @(negedge CLOCK_50); clear = 1'b1;
        @(negedge CLOCK_50); clear = 1'b0;
        model_clear();
    endtask

    task automatic pulse_read();
        @(negedge CLOCK_50); rd = 1'b1;
        @(negedge CLOCK_50); rd = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50); nReset = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        nReset = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLOCK_50);
        n_cmp++; if (avail_o !== 1'b0) begin n_fail++; $display("FAIL reset_avail: got %b want 0", avail_o); end
        n_cmp++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
        n_cmp++; if (fill_o !== 4'd0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", fill_o); end
        n_cmp++; if (left_o !== '0) begin n_fail++; $display("FAIL reset_left: got %h want 0", left_o); end
        n_cmp++; if (right_o !== '0) begin n_fail++; $display("FAIL reset_right: got %h want 0", right_o); end
        nReset = 1'b1;
        model_clear();
    endtask

    task automatic test_single_frame();
        preamble();
        send_frame(32'h12345678, 32'h9ABCDEF0, DW, HALF, 2);
        model_push(32'h12345678, 32'h9ABCDEF0);
        n_cmp++; if (avail_n6 !== 1'b0) begin n_fail++; $display("FAIL single_avail_before: got %b want 0", avail_n6); end
        n_cmp++; if (avail_n7 !== 1'b1) begin n_fail++; $display("FAIL single_avail_next: got %b want 1", avail_n7); end
        @(negedge CLOCK_50);
        n_cmp++; if (left_o !== 32'h12345678) begin n_fail++; $display("FAIL single_left: got %h want 12345678", left_o); end
        n_cmp++; if (right_o !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL single_right: got %h want 9abcdef0", right_o); end
        n_cmp++; if (fill_o !== exp_q.size()) begin n_fail++; $display("FAIL single_fill: got %0d want %0d", fill_o, exp_q.size()); end
        pulse_read();
        n_cmp++; if (avail_o !== 1'b0) begin n_fail++; $display("FAIL single_avail_after_read: got %b want 0", avail_o); end
        n_cmp++; if (fill_o !== 4'd0) begin n_fail++; $display("FAIL single_fill_after_read: got %0d want 0", fill_o); end
    endtask

    task automatic test_mid_word_start();
        logic [DW-1:0] l, r;
        // Streaming resumes in the middle of a right word.
        do_reset();
        for (int i = 0; i < 15; i++) bclk_cycle(1'($urandom_range(0, 1)), 1'b1, 0);
        n_cmp++; if (fill_o !== 4'd0) begin n_fail++; $display("FAIL midright_nopush: got %0d want 0", fill_o); end
        l = $urandom(); r = $urandom();
        send_frame(l, r, DW, HALF, 0);
        model_push(l, r);
        n_cmp++; if (fill_o !== exp_q.size()) begin n_fail++; $display("FAIL midright_fill: got %0d want %0d", fill_o, exp_q.size()); end
        n_cmp++; if ({left_o, right_o} !== exp_q[0]) begin n_fail++; $display("FAIL midright_head: got %h want %h", {left_o, right_o}, exp_q[0]); end
        pulse_read();
        // Reset lands in a left word; the right word that follows has no partner.
        for (int i = 0; i < 3; i++) bclk_cycle(1'($urandom_range(0, 1)), 1'b0, 0);
        do_reset();
        for (int i = 0; i < 10; i++) bclk_cycle(1'($urandom_range(0, 1)), 1'b0, 0);
        send_half(1'b1, $urandom(), DW, HALF, 0);
        n_cmp++; if (fill_o !== 4'd0) begin n_fail++; $display("FAIL midleft_no_orphan_right: got %0d want 0", fill_o); end
        l = $urandom(); r = $urandom();
        send_frame(l, r, DW, HALF, 0);
        model_push(l, r);
        n_cmp++; if ({left_o, right_o} !== exp_q[0]) begin n_fail++; $display("FAIL midleft_head: got %h want %h", {left_o, right_o}, exp_q[0]); end
        pulse_read();
    endtask

    task automatic test_overflow();
        logic [DW-1:0] l, r;
        pulse_clear();
        for (int f = 0; f < DEPTH + 1; f++) begin
            l = $urandom(); r = $urandom();
            send_frame(l, r, DW, HALF, 0);
            model_push(l, r);
        end
        n_cmp++; if (fill_o !== exp_q.size()) begin n_fail++; $display("FAIL ovf_fill: got %0d want %0d", fill_o, exp_q.size()); end
        n_cmp++; if (ovf_o !== model_ovf) begin n_fail++; $display("FAIL ovf_flag: got %b want %b", ovf_o, model_ovf); end
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge CLOCK_50);
            n_cmp++; if (avail_o !== 1'b1) begin n_fail++; $display("FAIL ovf_avail[%0d]: got %b want 1", k, avail_o); end
            n_cmp++; if ({left_o, right_o} !== exp_q[0]) begin n_fail++; $display("FAIL ovf_pop[%0d]: got %h want %h", k, {left_o, right_o}, exp_q[0]); end
            pulse_read();
        end
        n_cmp++; if (avail_o !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b want 0", avail_o); end
        pulse_read();
        n_cmp++; if (fill_o !== 4'd0) begin n_fail++; $display("FAIL ovf_empty_read: got %0d want 0", fill_o); end
    endtask

    task automatic test_push_pop_full();
        logic [DW-1:0] l, r;
        pulse_clear();
        n_cmp++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL ppf_clear_ovf: got %b want 0", ovf_o); end
        for (int f = 0; f < DEPTH; f++) begin
            l = $urandom(); r = $urandom();
            send_frame(l, r, DW, HALF, 0);
            model_push(l, r);
        end
        n_cmp++; if (fill_o !== exp_q.size()) begin n_fail++; $display("FAIL ppf_fill_full: got %0d want %0d", fill_o, exp_q.size()); end
        l = $urandom(); r = $urandom();
        send_frame(l, r, DW, HALF, 1);
        void'(exp_q.pop_front());
        model_push(l, r);
        n_cmp++; if (ovf_o !== model_ovf) begin n_fail++; $display("FAIL ppf_ovf: got %b want %b", ovf_o, model_ovf); end
        n_cmp++; if (fill_o !== exp_q.size()) begin n_fail++; $display("FAIL ppf_fill: got %0d want %0d", fill_o, exp_q.size()); end
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge CLOCK_50);
            n_cmp++; if ({left_o, right_o} !== exp_q[0]) begin n_fail++; $display("FAIL ppf_pop[%0d]: got %h want %h", k, {left_o, right_o}, exp_q[0]); end
            pulse_read();
        end
    endtask

    task automatic test_short_word();
        logic [DW-1:0] l, r;
        pulse_clear();
        preamble();
        l = {16'hFFFF, 16'($urandom())};
        r = $urandom();
        send_frame(l, r, 16, 17, 0);
        for (int i = 0; i < 3; i++) bclk_cycle(1'($urandom_range(0, 1)), 1'b0, 0);
        model_push(captured(l, 16), captured(r, 16));
        n_cmp++; if (fill_o !== exp_q.size()) begin n_fail++; $display("FAIL short_fill: got %0d want %0d", fill_o, exp_q.size()); end
        n_cmp++; if (left_o !== 32'hFFFF0000) begin n_fail++; $display("FAIL short_left: got %h want ffff0000", left_o); end
        n_cmp++; if (right_o !== exp_q[0][DW-1:0]) begin n_fail++; $display("FAIL short_right: got %h want %h", right_o, exp_q[0][DW-1:0]); end
        pulse_read();
    endtask

    task automatic test_clear();
        logic [DW-1:0] l, r;
        pulse_clear();
        preamble();
        for (int f = 0; f < 3; f++) begin
            l = $urandom(); r = $urandom();
            send_frame(l, r, DW, HALF, 0);
            model_push(l, r);
        end
        n_cmp++; if (fill_o !== exp_q.size()) begin n_fail++; $display("FAIL clear_fill_before: got %0d want %0d", fill_o, exp_q.size()); end
        send_frame($urandom(), $urandom(), DW, HALF, 3);
        model_clear();
        n_cmp++; if (fill_o !== 4'd0) begin n_fail++; $display("FAIL clear_fill: got %0d want 0", fill_o); end
        n_cmp++; if (avail_o !== 1'b0) begin n_fail++; $display("FAIL clear_avail: got %b want 0", avail_o); end
        n_cmp++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL clear_ovf: got %b want 0", ovf_o); end
    endtask

    task automatic test_reset_mid_shift();
        logic [DW-1:0] l, r;
        send_frame(32'hA5A5_0F0F, 32'h5A5A_F0F0, DW, HALF, 0);
        model_push(32'hA5A5_0F0F, 32'h5A5A_F0F0);
        n_cmp++; if (fill_o !== exp_q.size()) begin n_fail++; $display("FAIL rst_fill_before: got %0d want %0d", fill_o, exp_q.size()); end
        for (int i = 0; i < 10; i++) bclk_cycle(1'($urandom_range(0, 1)), 1'b0, 0);
        @(negedge CLOCK_50);
        #3 nReset = 1'b0;
        #1;
        n_cmp++; if (avail_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_avail: got %b want 0", avail_o); end
        n_cmp++; if (fill_o !== 4'd0) begin n_fail++; $display("FAIL rst_async_fill: got %0d want 0", fill_o); end
        n_cmp++; if (left_o !== '0) begin n_fail++; $display("FAIL rst_async_left: got %h want 0", left_o); end
        n_cmp++; if (right_o !== '0) begin n_fail++; $display("FAIL rst_async_right: got %h want 0", right_o); end
        repeat (3) @(negedge CLOCK_50);
        nReset = 1'b1;
        model_clear();
        for (int i = 0; i < HALF - 10; i++) bclk_cycle(1'($urandom_range(0, 1)), 1'b0, 0);
        send_half(1'b1, $urandom(), DW, HALF, 0);
        n_cmp++; if (fill_o !== 4'd0) begin n_fail++; $display("FAIL rst_partial_discard: got %0d want 0", fill_o); end
        l = $urandom(); r = $urandom();
        send_frame(l, r, DW, HALF, 0);
        model_push(l, r);
        n_cmp++; if (fill_o !== exp_q.size()) begin n_fail++; $display("FAIL rst_restart_fill: got %0d want %0d", fill_o, exp_q.size()); end
        n_cmp++; if ({left_o, right_o} !== exp_q[0]) begin n_fail++; $display("FAIL rst_restart_head: got %h want %h", {left_o, right_o}, exp_q[0]); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_mid_word_start();
        test_overflow();
        test_push_pop_full();
        test_short_word();
        test_clear();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
